// File: rtl/des_pkg.sv
// Shared definitions for the DES datapath: block geometry, packer FSM states
// and the PKCS#7 pad-byte helper.
package des_pkg;

  localparam int BLOCK_W         = 64;
  localparam int BYTES_PER_BLOCK = 8;

  typedef enum logic [1:0] {
    ACCUM    = 2'd0,
    PAD      = 2'd1,
    PAD_FULL = 2'd2
  } packer_state_t;

  // PKCS#7: every pad byte carries the number of pad bytes in the block
  function automatic logic [7:0] pad_value(input logic [2:0] cnt);
    pad_value = 8'd8 - {5'd0, cnt};
  endfunction

endpackage

// File: rtl/des_block_fifo.sv
// Synchronous BLOCK_W x DEPTH block FIFO; pointers carry one extra wrap bit so
// full and empty are distinguishable without an occupancy counter.
module des_block_fifo
  import des_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               clear,
  input  logic               push,
  input  logic [BLOCK_W-1:0] din,
  input  logic               pop,
  output logic [BLOCK_W-1:0] dout,
  output logic               full,
  output logic               empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]        wr_ptr_r;
  logic [AW:0]        rd_ptr_r;
  logic [BLOCK_W-1:0] mem_r [DEPTH];
  logic               do_push_s;
  logic               do_pop_s;

  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign do_push_s = push && !full && !clear;
  assign do_pop_s  = pop && !empty && !clear;
  assign dout      = mem_r[rd_ptr_r[AW-1:0]];

  // Pointer update; a simultaneous push and pop both advance
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else if (clear) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
    end
  end

  // Storage array write port
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r[AW-1:0]] <= din;
  end

endmodule

// File: rtl/des_block_packer.sv
// Packs a byte stream MSB-first into 64-bit blocks, pads the tail and releases
// queued blocks to Triple-DES once keys are loaded. Option: DES_PACKER_PAD_EN.
module des_block_packer
  import des_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int MIN_GAP    = 0
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               clear,
  input  logic [7:0]         byte_in,
  input  logic               byte_valid,
  input  logic               byte_last,
  output logic               byte_ready,
  input  logic               keys_ready,
  output logic [BLOCK_W-1:0] raw_data,
  output logic               data_valid_in,
  output logic [15:0]        block_count,
  output logic               busy
);

  packer_state_t      state_r, state_next;
  logic [2:0]         cnt_r, cnt_next;
  logic [BLOCK_W-1:0] acc_r, acc_next;
  logic [BLOCK_W-1:0] blk_s, pad_blk_s, push_data_s, fifo_dout_s;
  logic [7:0]         pad_byte_s;
  logic               push_s, pop_s, xfer_s;
  logic               fifo_full_s, fifo_empty_s;
  logic [15:0]        gap_r;

  assign byte_ready = (state_r == ACCUM) && !fifo_full_s;
  assign xfer_s     = byte_valid && byte_ready && !clear;
  assign pop_s      = keys_ready && !fifo_empty_s && (gap_r == 16'd0) && !clear;
  assign busy       = (state_r != ACCUM) || (cnt_r != 3'd0) || !fifo_empty_s;

`ifdef DES_PACKER_PAD_EN
  assign pad_byte_s = pad_value(cnt_r);
`else
  assign pad_byte_s = 8'h00;
`endif

  // Current byte merged into its slot, and the tail-padded variant of the block
  always_comb begin
    blk_s     = '0;
    pad_blk_s = '0;
    for (int i = 0; i < BYTES_PER_BLOCK; i++) begin
      blk_s[BLOCK_W-1-8*i -: 8]     = (cnt_r == 3'(i)) ? byte_in : acc_r[BLOCK_W-1-8*i -: 8];
      pad_blk_s[BLOCK_W-1-8*i -: 8] = (3'(i) < cnt_r) ? acc_r[BLOCK_W-1-8*i -: 8] : pad_byte_s;
    end
  end

  // Packer next-state, accumulator and FIFO push control
  always_comb begin
    state_next  = state_r;
    cnt_next    = cnt_r;
    acc_next    = acc_r;
    push_s      = 1'b0;
    push_data_s = blk_s;
    if (clear) begin
      state_next = ACCUM;
      cnt_next   = 3'd0;
      acc_next   = '0;
    end else begin
      case (state_r)
        ACCUM: begin
          if (xfer_s && (cnt_r == 3'd7)) begin
            push_s   = 1'b1;
            cnt_next = 3'd0;
            acc_next = '0;
`ifdef DES_PACKER_PAD_EN
            state_next = byte_last ? PAD_FULL : ACCUM;
`else
            state_next = ACCUM;
`endif
          end else if (xfer_s) begin
            acc_next   = blk_s;
            cnt_next   = cnt_r + 3'd1;
            state_next = byte_last ? PAD : ACCUM;
          end else begin
            state_next = ACCUM;
          end
        end
        PAD: begin
          if (!fifo_full_s) begin
            push_s      = 1'b1;
            push_data_s = pad_blk_s;
            state_next  = ACCUM;
            cnt_next    = 3'd0;
            acc_next    = '0;
          end else begin
            state_next = PAD;
          end
        end
`ifdef DES_PACKER_PAD_EN
        PAD_FULL: begin
          if (!fifo_full_s) begin
            push_s      = 1'b1;
            push_data_s = {BYTES_PER_BLOCK{pad_value(3'd0)}};
            state_next  = ACCUM;
          end else begin
            state_next = PAD_FULL;
          end
        end
`endif
        default: begin
          state_next = ACCUM;
          cnt_next   = 3'd0;
          acc_next   = '0;
        end
      endcase
    end
  end

  // Packer state registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r <= ACCUM;
      cnt_r   <= 3'd0;
      acc_r   <= '0;
    end else begin
      state_r <= state_next;
      cnt_r   <= cnt_next;
      acc_r   <= acc_next;
    end
  end

  // Emit side: pop into raw_data, strobe, count and pace with the gap counter
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      raw_data      <= '0;
      data_valid_in <= 1'b0;
      block_count   <= 16'd0;
      gap_r         <= 16'd0;
    end else if (clear) begin
      data_valid_in <= 1'b0;
      block_count   <= 16'd0;
      gap_r         <= 16'd0;
    end else if (pop_s) begin
      raw_data      <= fifo_dout_s;
      data_valid_in <= 1'b1;
      block_count   <= block_count + 16'd1;
      gap_r         <= 16'(MIN_GAP);
    end else begin
      data_valid_in <= 1'b0;
      gap_r         <= (gap_r != 16'd0) ? (gap_r - 16'd1) : 16'd0;
    end
  end

  des_block_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (clear),
    .push  (push_s),
    .din   (push_data_s),
    .pop   (pop_s),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

endmodule

// File: tb/tb_des_block_packer.sv
// Directed self-checking bench for des_block_packer; expectations follow the
// DES_PACKER_PAD_EN setting of the build. A second instance runs with MIN_GAP=2.
module tb_des_block_packer;

`ifdef DES_PACKER_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        clear = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_last = 1'b0;
  logic        keys_ready = 1'b0;

  logic        byte_ready, data_valid_in, busy;
  logic [63:0] raw_data;
  logic [15:0] block_count;
  logic        byte_ready_g, data_valid_in_g, busy_g;
  logic [63:0] raw_data_g;
  logic [15:0] block_count_g;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  logic [63:0] q0[$];
  int          s0[$];
  logic [63:0] q1[$];
  int          s1[$];

  des_block_packer #(.FIFO_DEPTH(4), .MIN_GAP(0)) dut (
    .clk(clk), .n_rst(n_rst), .clear(clear), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_last(byte_last), .byte_ready(byte_ready),
    .keys_ready(keys_ready), .raw_data(raw_data), .data_valid_in(data_valid_in),
    .block_count(block_count), .busy(busy)
  );

  des_block_packer #(.FIFO_DEPTH(4), .MIN_GAP(2)) dut_gap (
    .clk(clk), .n_rst(n_rst), .clear(clear), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_last(byte_last), .byte_ready(byte_ready_g),
    .keys_ready(keys_ready), .raw_data(raw_data_g), .data_valid_in(data_valid_in_g),
    .block_count(block_count_g), .busy(busy_g)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (data_valid_in) begin
      q0.push_back(raw_data);
      s0.push_back(cyc);
    end
    if (data_valid_in_g) begin
      q1.push_back(raw_data_g);
      s1.push_back(cyc);
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic flush_logs();
    q0.delete(); s0.delete(); q1.delete(); s1.delete();
  endtask

  task automatic do_reset();
    byte_valid = 1'b0; byte_last = 1'b0; clear = 1'b0; keys_ready = 1'b0;
    n_rst = 1'b0;
    tick(2);
    n_rst = 1'b1;
    tick(1);
    flush_logs();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int waitc = 0;
    byte_valid = 1'b1; byte_in = b; byte_last = last;
    while (!byte_ready && waitc < 200) begin
      tick(1);
      waitc++;
    end
    if (!byte_ready) begin
      total_cnt++;
      $display("FAIL send_timeout: byte %h not accepted within %0d cycles", b, waitc);
    end else begin
      tick(1);
    end
    byte_valid = 1'b0; byte_last = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] start, input int n, input logic last);
    for (int i = 0; i < n; i++) send_byte(start + 8'(i), last && (i == n - 1));
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++; if (raw_data !== 64'h0) $display("FAIL reset_raw: got %h want 0", raw_data); else pass_cnt++;
    total_cnt++; if (data_valid_in !== 1'b0) $display("FAIL reset_dv: got %b want 0", data_valid_in); else pass_cnt++;
    total_cnt++; if (block_count !== 16'd0) $display("FAIL reset_count: got %0d want 0", block_count); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (byte_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", byte_ready); else pass_cnt++;
  endtask

  task automatic test_full_block();
    do_reset();
    keys_ready = 1'b1;
    send_seq(8'h01, 8, 1'b1);
    tick(1);
    total_cnt++; if (data_valid_in !== 1'b1) $display("FAIL full_latency_dv: got %b want 1", data_valid_in); else pass_cnt++;
    total_cnt++; if (raw_data !== 64'h0102030405060708) $display("FAIL full_latency_raw: got %h want 0102030405060708", raw_data); else pass_cnt++;
    tick(10);
    total_cnt++; if (q0.size() !== (PAD_EN ? 2 : 1)) $display("FAIL full_pulses: got %0d want %0d", q0.size(), PAD_EN ? 2 : 1); else pass_cnt++;
    total_cnt++;
    if (((q0.size() > 1) ? q0[1] : 64'h0) !== (PAD_EN ? 64'h0808080808080808 : 64'h0))
      $display("FAIL full_pad_block: got %h want %h", (q0.size() > 1) ? q0[1] : 64'h0, PAD_EN ? 64'h0808080808080808 : 64'h0);
    else pass_cnt++;
    total_cnt++; if (block_count !== (PAD_EN ? 16'd2 : 16'd1)) $display("FAIL full_count: got %0d want %0d", block_count, PAD_EN ? 2 : 1); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL full_busy: got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_partial();
    logic [63:0] exp_blk;
    exp_blk = PAD_EN ? 64'hAABBCC0505050505 : 64'hAABBCC0000000000;
    do_reset();
    keys_ready = 1'b1;
    send_byte(8'hAA, 1'b0); send_byte(8'hBB, 1'b0); send_byte(8'hCC, 1'b1);
    tick(10);
    total_cnt++; if (q0.size() !== 1) $display("FAIL partial_pulses: got %0d want 1", q0.size()); else pass_cnt++;
    total_cnt++;
    if (((q0.size() > 0) ? q0[0] : 64'h0) !== exp_blk)
      $display("FAIL partial_data: got %h want %h", (q0.size() > 0) ? q0[0] : 64'h0, exp_blk);
    else pass_cnt++;
    total_cnt++; if (block_count !== 16'd1) $display("FAIL partial_count: got %0d want 1", block_count); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int span;
    do_reset();
    for (int i = 0; i < 32; i++) send_byte(8'(i + 1), 1'b0);
    total_cnt++; if (byte_ready !== 1'b0) $display("FAIL bp_ready_low: got %b want 0", byte_ready); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1) $display("FAIL bp_busy: got %b want 1", busy); else pass_cnt++;
    total_cnt++; if (q0.size() !== 0) $display("FAIL bp_no_emit: got %0d pulses want 0", q0.size()); else pass_cnt++;
    keys_ready = 1'b1;
    tick(6);
    span = (s0.size() > 3) ? (s0[3] - s0[0]) : -1;
    total_cnt++; if (q0.size() !== 4) $display("FAIL bp_drain_count: got %0d want 4", q0.size()); else pass_cnt++;
    total_cnt++; if (span !== 3) $display("FAIL bp_drain_consecutive: span %0d want 3", span); else pass_cnt++;
    total_cnt++;
    if (((q0.size() > 3) ? q0[3] : 64'h0) !== 64'h191A1B1C1D1E1F20)
      $display("FAIL bp_block3: got %h want 191a1b1c1d1e1f20", (q0.size() > 3) ? q0[3] : 64'h0);
    else pass_cnt++;
    total_cnt++; if (byte_ready !== 1'b1) $display("FAIL bp_ready_back: got %b want 1", byte_ready); else pass_cnt++;
    for (int i = 32; i < 40; i++) send_byte(8'(i + 1), i == 39);
    tick(8);
    total_cnt++; if (q0.size() !== (PAD_EN ? 6 : 5)) $display("FAIL bp_total: got %0d want %0d", q0.size(), PAD_EN ? 6 : 5); else pass_cnt++;
    total_cnt++;
    if (((q0.size() > 4) ? q0[4] : 64'h0) !== 64'h2122232425262728)
      $display("FAIL bp_block4: got %h want 2122232425262728", (q0.size() > 4) ? q0[4] : 64'h0);
    else pass_cnt++;
  endtask

  task automatic test_min_gap();
    int d0, d1;
    do_reset();
    send_seq(8'h01, 24, 1'b0);
    tick(1);
    flush_logs();
    keys_ready = 1'b1;
    tick(15);
    d0 = (s1.size() > 1) ? (s1[1] - s1[0]) : -1;
    d1 = (s1.size() > 2) ? (s1[2] - s1[1]) : -1;
    total_cnt++; if (q1.size() !== 3) $display("FAIL gap_pulses: got %0d want 3", q1.size()); else pass_cnt++;
    total_cnt++; if (d0 !== 3) $display("FAIL gap_spacing0: got %0d want 3", d0); else pass_cnt++;
    total_cnt++; if (d1 !== 3) $display("FAIL gap_spacing1: got %0d want 3", d1); else pass_cnt++;
    total_cnt++; if (block_count_g !== 16'd3) $display("FAIL gap_count: got %0d want 3", block_count_g); else pass_cnt++;
  endtask

  task automatic test_clear();
    do_reset();
    keys_ready = 1'b1;
    send_seq(8'h01, 8, 1'b0);
    tick(4);
    keys_ready = 1'b0;
    send_seq(8'h31, 8, 1'b0);
    send_seq(8'h41, 5, 1'b0);
    total_cnt++; if (block_count !== 16'd1) $display("FAIL clr_pre_count: got %0d want 1", block_count); else pass_cnt++;
    flush_logs();
    clear = 1'b1; keys_ready = 1'b1;
    byte_valid = 1'b1; byte_in = 8'hEE; byte_last = 1'b0;
    tick(1);
    clear = 1'b0; byte_valid = 1'b0;
    total_cnt++; if (data_valid_in !== 1'b0) $display("FAIL clr_dv: got %b want 0", data_valid_in); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL clr_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (block_count !== 16'd0) $display("FAIL clr_count: got %0d want 0", block_count); else pass_cnt++;
    tick(4);
    total_cnt++; if (q0.size() !== 0) $display("FAIL clr_no_pulse: got %0d want 0", q0.size()); else pass_cnt++;
    send_seq(8'h11, 8, 1'b0);
    tick(3);
    total_cnt++;
    if (((q0.size() > 0) ? q0[0] : 64'h0) !== 64'h1112131415161718)
      $display("FAIL clr_next_block: got %h want 1112131415161718", (q0.size() > 0) ? q0[0] : 64'h0);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    do_reset();
    keys_ready = 1'b1;
    send_seq(8'h01, 8, 1'b0);
    tick(3);
    send_seq(8'hA1, 3, 1'b0);
    #2 n_rst = 1'b0;
    #1;
    total_cnt++; if (raw_data !== 64'h0) $display("FAIL arst_raw: got %h want 0", raw_data); else pass_cnt++;
    total_cnt++; if (block_count !== 16'd0) $display("FAIL arst_count: got %0d want 0", block_count); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL arst_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (byte_ready !== 1'b1) $display("FAIL arst_ready: got %b want 1", byte_ready); else pass_cnt++;
    tick(1);
    n_rst = 1'b1;
    tick(1);
    flush_logs();
    send_seq(8'h21, 8, 1'b0);
    tick(3);
    total_cnt++;
    if (((q0.size() > 0) ? q0[0] : 64'h0) !== 64'h2122232425262728)
      $display("FAIL arst_next_block: got %h want 2122232425262728", (q0.size() > 0) ? q0[0] : 64'h0);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_full_block();
    test_partial();
    test_backpressure();
    test_min_gap();
    test_clear();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/des_block_packer.md
# des_block_packer

Upstream feeder for the ECCDH3DES top level. Accepts a byte stream over a valid/ready handshake, packs it MSB-first into 64-bit blocks, pads the final partial block, and buffers completed blocks in a small FIFO. Blocks are released to the Triple-DES input (`raw_data` / `data_valid_in`) only once session keys are established.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: block FIFO entries; power of 2, minimum 2.
- `MIN_GAP`, 0: minimum idle cycles between consecutive `data_valid_in` pulses.

Ports:
- `clk` in 1: the block's single clock.
- `n_rst` in 1: reset, asynchronous and active-low.
- `clear` in 1: synchronous flush; drops the partial block and FIFO contents.
- `byte_in` in 8: data byte.
- `byte_valid` in 1: `byte_in` valid.
- `byte_last` in 1: final byte of the message; qualified by `byte_valid`.
- `byte_ready` out 1: packer can accept a byte this cycle.
- `keys_ready` in 1: level; high when DES keys are loaded (driven from `des_done`).
- `raw_data` out 64: block to DES.
- `data_valid_in` out 1: one-cycle strobe; `raw_data` is valid in that cycle.
- `block_count` out 16: blocks emitted since reset or clear.
- `busy` out 1: partial block, pending pad, or non-empty FIFO.

## Operation
- FSM states: ACCUM, PAD, PAD_FULL.
- ACCUM:
  - A byte transfers when `byte_valid` and `byte_ready` are both high.
  - Byte index `cnt` (0..7) selects the position: byte 0 goes to bits [63:56], byte 7 to [7:0].
  - When `cnt`=7, the assembled block is pushed to the FIFO on the same edge and `cnt` returns to 0.
- `byte_last` handling:
  - If `byte_last` arrives with `cnt`<7: go to PAD.
  - If `byte_last` arrives with `cnt`=7: push the block, then go to PAD_FULL.
- PAD: fill bytes `cnt`..7 with the pad value (see Configuration), push when the FIFO is not full, then return to ACCUM with `cnt`=0.
- PAD_FULL: push the all-pad block when the FIFO is not full, then return to ACCUM. If padding is disabled, PAD_FULL is skipped.
- `byte_ready` = (state==ACCUM) && !fifo_full. There is no look-ahead, so a push is never blocked.
- Emit side: when `keys_ready` is high, the FIFO is non-empty, and the gap counter is 0:
  - Pop one block into the `raw_data` register.
  - Pulse `data_valid_in` for one cycle.
  - Increment `block_count` (wraps 0xFFFF→0).
  - Load the gap counter with `MIN_GAP`.
- `raw_data` holds its last value between pulses.
- A push and a pop in the same cycle are both performed; the occupancy stays the same.
- `keys_ready` low only stalls emission; accumulation continues until the FIFO is full.
- `clear`:
  - Returns the FSM to ACCUM with `cnt`=0.
  - Empties the FIFO and zeroes `block_count` and the gap counter.
  - Suppresses any emit in that cycle.
  - Input bytes presented in that cycle are dropped.

## Timing
- Reset values:
  - `raw_data`=0, `data_valid_in`=0, `block_count`=0, `busy`=0.
  - `byte_ready`=1, because ACCUM with an empty FIFO is the reset state.
  - Internal state: FSM=ACCUM, `cnt`=0, FIFO empty.
- Latency: completing byte accepted at edge T → block in FIFO after T → `data_valid_in` high in the cycle after edge T+1, provided `keys_ready` is high.
- PAD adds one cycle; PAD_FULL adds one more.
- Throughput:
  - Input: one byte per cycle.
  - Output: one block per `MIN_GAP`+1 cycles.
- Reset asserted mid-operation clears everything immediately; no partial block survives it.

## Configuration
- `DES_PACKER_PAD_EN` defined: PKCS#7 padding.
  - Pad byte value = 8−`cnt`.
  - A message that ends on a block boundary gets an extra block of eight 0x08 bytes.
- `DES_PACKER_PAD_EN` undefined:
  - Remaining bytes are zero-filled.
  - No extra block is generated; PAD_FULL is unreachable.
  - `byte_last` at `cnt`=7 behaves as a normal completing byte.

## Structure
- The shared package `des_pkg` holds:
  - `BLOCK_W`=64 and `BYTES_PER_BLOCK`=8.
  - The packer state enum `packer_state_t`.
  - The pad-value function.
- Sub-module `des_block_fifo`: synchronous FIFO of `BLOCK_W`×`FIFO_DEPTH`.
  - Ports: push, pop, clear, full, empty.
  - Pointers are one bit wider than the address for full/empty detection.

## Test plan
- 8 bytes 0x01..0x08 with `byte_last` on the 8th, pad enabled, `keys_ready`=1 → two pulses: `raw_data`=0x0102030405060708, then 0x0808080808080808; `block_count`=2.
- 3 bytes 0xAA,0xBB,0xCC with last → `raw_data`=0xAABBCC0505050505 (pad enabled) or 0xAABBCC0000000000 (pad disabled).
- `keys_ready`=0 while streaming 40 bytes, `FIFO_DEPTH`=4:
  - `byte_ready` drops after 32 bytes.
  - Raising `keys_ready` drains four blocks on consecutive cycles and `byte_ready` reasserts.
- `MIN_GAP`=2 with 3 queued blocks → pulses 3 cycles apart.
- `clear` after 5 bytes plus 1 queued block → FIFO empty, `busy`=0, `block_count`=0, no pulse.
- `n_rst` asserted mid-block → all outputs at reset values asynchronously; the next message packs from byte 0.
